// File: rtl/adma_data_write_pkg.sv
// Shared definitions for the ADMA2 write-direction engine.
// This file holds the FSM state encoding, the descriptor field positions,
// the Act codes, and the helper that turns a byte length into a word count.
package adma_data_write_pkg;

    // FSM states, two-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_XFER  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } adma_wr_state_e;

    // Descriptor layout: [95:32] address, [31:16] length in bytes, [15:0] attributes
    localparam int ADDR_HI    = 95;
    localparam int ADDR_LO    = 32;
    localparam int LEN_HI     = 31;
    localparam int LEN_LO     = 16;
    localparam int ATTR_VALID = 0;
    localparam int ATTR_END   = 1;
    localparam int ATTR_INT   = 2;
    localparam int ACT_HI     = 5;
    localparam int ACT_LO     = 4;

    // Act field codes
    localparam logic [1:0] ACT_NOP  = 2'b00;
    localparam logic [1:0] ACT_RSV  = 2'b01;
    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    localparam int COUNT_W = 15;

    // Convert a byte length to a count of 32-bit words, rounding up.
    // A length of zero encodes the maximum of 65536 bytes, which is 16384 words.
    function automatic logic [COUNT_W-1:0] words_from_len(input logic [15:0] len);
        logic [16:0] rounded;
        rounded = {1'b0, len} + 17'd3;
        if (len == 16'd0) begin
            words_from_len = 15'd16384;
        end else begin
            words_from_len = rounded[16:2];
        end
    endfunction

endpackage

// File: rtl/adma_timeout_counter.sv
// Starvation timer for the ADMA write engine.
// It counts cycles while i_enable is high and clears when i_clear is high.
// o_expired flags the cycle in which the count reaches LIMIT, so the owner
// can leave its state on that same edge. LIMIT must be at least 2.
module adma_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // Count enabled cycles; the clear input takes priority over counting
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= {CW{1'b0}};
        end else if (i_clear) begin
            r_count <= {CW{1'b0}};
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/adma_data_write.sv
// ADMA2 write-direction engine.
// It takes one fetched transfer descriptor and copies the payload from the
// first-word-fall-through data FIFO into system RAM, one word per cycle,
// starting at the descriptor address. Writing a word and popping the FIFO
// happen in the same cycle, so the RAM and FIFO strobes are combinational.
module adma_data_write
    import adma_data_write_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH+31:0] address_descriptor,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_write,
    output logic                  ram_read,
    output logic                  busy,
    output logic                  transfer_done,
    output logic                  transfer_error,
    output logic                  transfer_end,
    output logic                  transfer_int
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    adma_wr_state_e        r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [COUNT_W-1:0]    r_count;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_end;
    logic                  r_int;

    logic [ADDR_WIDTH-1:0] w_desc_addr;
    logic [15:0]           w_desc_len;
    logic                  w_attr_valid;
    logic                  w_attr_end;
    logic                  w_attr_int;
    logic [1:0]            w_attr_act;
    logic                  w_unused_attr;
    logic                  w_reject;
    logic                  w_in_xfer;
    logic                  w_write;
    logic                  w_tmr_clear;
    logic                  w_tmr_enable;
    logic                  w_tmr_expired;

    // Descriptor field extraction
    assign w_desc_addr   = address_descriptor[ADDR_LO +: ADDR_WIDTH];
    assign w_desc_len    = address_descriptor[LEN_HI:LEN_LO];
    assign w_attr_valid  = address_descriptor[ATTR_VALID];
    assign w_attr_end    = address_descriptor[ATTR_END];
    assign w_attr_int    = address_descriptor[ATTR_INT];
    assign w_attr_act    = address_descriptor[ACT_HI:ACT_LO];
    assign w_unused_attr = ^{address_descriptor[15:6], address_descriptor[3]};

    // Only valid, transfer-type descriptors that point at a word-aligned address are accepted
    assign w_reject = !w_attr_valid || (w_attr_act != ACT_TRAN) || (w_desc_addr[1:0] != 2'b00);

    // A word moves whenever the FIFO has data during XFER; a stop request masks the move
    assign w_in_xfer = (r_state == ST_XFER);
    assign w_write   = w_in_xfer && !fifo_empty && !stop;

    // The starvation timer only runs inside XFER and restarts on every word moved
    assign w_tmr_clear  = !w_in_xfer || w_write;
    assign w_tmr_enable = w_in_xfer && fifo_empty;

    adma_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_tmr_expired)
    );

    assign fifo_read      = w_write;
    assign ram_write      = w_write;
    assign ram_data_out   = w_write ? fifo_data : {DATA_WIDTH{1'b0}};
    assign ram_address    = r_addr;
    assign ram_read       = 1'b0;
    assign busy           = r_busy;
    assign transfer_done  = r_done;
    assign transfer_error = r_error;
    assign transfer_end   = r_end;
    assign transfer_int   = r_int;

    // Transfer FSM together with its address, word-count and status registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_count <= {COUNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_end   <= 1'b0;
            r_int   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_end <= w_attr_end;
                        r_int <= w_attr_int;
                        if (w_reject) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= ST_XFER;
                            r_busy  <= 1'b1;
                            r_addr  <= w_desc_addr;
                            r_count <= words_from_len(w_desc_len);
                        end
                    end
                end
                ST_XFER: begin
                    if (stop) begin
                        // An abort drops the rest of the descriptor
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_addr  <= {ADDR_WIDTH{1'b0}};
                        r_count <= {COUNT_W{1'b0}};
                    end else if (w_write) begin
                        r_addr  <= r_addr + ADDR_STEP;
                        r_count <= r_count - 15'd1;
                        if (r_count == 15'd1) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_tmr_expired) begin
                        r_state <= ST_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Done stays up until start drops, so a new start needs one low edge first
                    if (stop || !start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_addr  <= {ADDR_WIDTH{1'b0}};
                        r_count <= {COUNT_W{1'b0}};
                    end
                end
                ST_ERROR: begin
                    if (stop || !start) begin
                        r_state <= ST_IDLE;
                        r_error <= 1'b0;
                        r_addr  <= {ADDR_WIDTH{1'b0}};
                        r_count <= {COUNT_W{1'b0}};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_addr  <= {ADDR_WIDTH{1'b0}};
                    r_count <= {COUNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adma_data_write.sv
// Directed testbench for adma_data_write.
// Inputs change on the falling clock edge. Outputs are sampled 1 ns later,
// which is away from the rising edge where the design's state changes.
module tb_adma_data_write;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        stop;
    logic [95:0] address_descriptor;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_read;
    logic [63:0] ram_address;
    logic [31:0] ram_data_out;
    logic        ram_write;
    logic        ram_read;
    logic        busy;
    logic        transfer_done;
    logic        transfer_error;
    logic        transfer_end;
    logic        transfer_int;

    adma_data_write #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .start              (start),
        .stop               (stop),
        .address_descriptor (address_descriptor),
        .fifo_data          (fifo_data),
        .fifo_empty         (fifo_empty),
        .fifo_read          (fifo_read),
        .ram_address        (ram_address),
        .ram_data_out       (ram_data_out),
        .ram_write          (ram_write),
        .ram_read           (ram_read),
        .busy               (busy),
        .transfer_done      (transfer_done),
        .transfer_error     (transfer_error),
        .transfer_end       (transfer_end),
        .transfer_int       (transfer_int)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // FIFO model: word i is 0xA0+i; a gap of empty cycles can be placed before word gap_at
    int head;
    int fifo_len;
    int gap_at;
    int gap_left;

    // Write log
    int          nwr;
    int          n_busy;
    int          n_strobe_bad = 0;
    int          n_dirty = 0;
    logic [63:0] wa [16];
    logic [31:0] wd [16];
    logic [63:0] last_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present the FIFO head, log the strobes, then advance to the next falling edge
    task automatic cyc();
        if (head >= fifo_len) begin
            fifo_empty = 1'b1;
        end else if (head == gap_at && gap_left > 0) begin
            fifo_empty = 1'b1;
            gap_left--;
        end else begin
            fifo_empty = 1'b0;
        end
        fifo_data = fifo_empty ? 32'hDEAD_BEEF : (32'h0000_00A0 + 32'(head));
        #1;
        if (busy) n_busy++;
        if (ram_write !== fifo_read) n_strobe_bad++;
        if (!ram_write && ram_data_out !== 32'h0) n_dirty++;
        if (ram_write) begin
            if (nwr < 16) begin
                wa[nwr] = ram_address;
                wd[nwr] = ram_data_out;
            end
            last_a = ram_address;
            nwr++;
        end
        if (fifo_read) head++;
        @(negedge CLK);
    endtask

    // Start a descriptor and run until done/error or the cycle budget runs out
    task automatic do_xfer(input logic [63:0] a, input logic [15:0] len,
                           input logic [15:0] attr, input int budget);
        address_descriptor = {a, len, attr};
        start  = 1'b1;
        nwr    = 0;
        n_busy = 0;
        head   = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (transfer_done || transfer_error) break;
        end
    endtask

    // Drop start for one edge so the engine returns to IDLE
    task automatic release_start();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        address_descriptor = 96'h0;
        fifo_empty = 1'b1;
        fifo_data  = 32'h0;
        head = 0; fifo_len = 0; gap_at = -1; gap_left = 0;
        nwr = 0; n_busy = 0; last_a = 64'h0;

        // Reset state
        #2;
        chk("rst_busy",  {63'h0, busy}, 64'h0);
        chk("rst_done",  {63'h0, transfer_done}, 64'h0);
        chk("rst_error", {63'h0, transfer_error}, 64'h0);
        chk("rst_end",   {63'h0, transfer_end}, 64'h0);
        chk("rst_wr",    {63'h0, ram_write}, 64'h0);
        chk("rst_rd",    {63'h0, ram_read}, 64'h0);
        chk("rst_addr",  ram_address, 64'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // 1: four back-to-back words from 0x1000
        fifo_len = 100; gap_at = -1; gap_left = 0;
        do_xfer(64'h1000, 16'd16, 16'h0021, 50);
        chk("t1_done", {63'h0, transfer_done}, 64'h1);
        chk("t1_err",  {63'h0, transfer_error}, 64'h0);
        chk("t1_nwr",  64'(nwr), 64'd4);
        chk("t1_busy_cycles", 64'(n_busy), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_addr%0d", i), wa[i], 64'h1000 + 64'(4 * i));
            chk($sformatf("t1_data%0d", i), {32'h0, wd[i]}, 64'hA0 + 64'(i));
        end
        chk("t1_end", {63'h0, transfer_end}, 64'h0);
        cyc();
        cyc();
        chk("t1_done_held", {63'h0, transfer_done}, 64'h1);
        chk("t1_nwr_held",  64'(nwr), 64'd4);
        release_start();
        chk("t1_done_clr", {63'h0, transfer_done}, 64'h0);

        // 2a: len=6 rounds up to 2 words; End and Int are latched
        do_xfer(64'h2000, 16'd6, 16'h0027, 50);
        chk("t2_done", {63'h0, transfer_done}, 64'h1);
        chk("t2_nwr",  64'(nwr), 64'd2);
        chk("t2_addr1", wa[1], 64'h2004);
        chk("t2_end", {63'h0, transfer_end}, 64'h1);
        chk("t2_int", {63'h0, transfer_int}, 64'h1);
        release_start();
        chk("t2_end_kept", {63'h0, transfer_end}, 64'h1);

        // 2b: len=0 means 16384 words
        fifo_len = 20000;
        do_xfer(64'h10000, 16'd0, 16'h0021, 17000);
        chk("t2z_done", {63'h0, transfer_done}, 64'h1);
        chk("t2z_nwr",  64'(nwr), 64'd16384);
        chk("t2z_last", last_a, 64'h1_FFFC);
        release_start();

        // 3a: three empty cycles in the middle do not cause an error
        fifo_len = 100; gap_at = 2; gap_left = 3;
        do_xfer(64'h3000, 16'd16, 16'h0021, 50);
        chk("t3_done", {63'h0, transfer_done}, 64'h1);
        chk("t3_err",  {63'h0, transfer_error}, 64'h0);
        chk("t3_nwr",  64'(nwr), 64'd4);
        chk("t3_busy_cycles", 64'(n_busy), 64'd7);
        chk("t3_data2", {32'h0, wd[2]}, 64'hA2);
        chk("t3_addr3", wa[3], 64'h300C);
        release_start();

        // 3b: eight empty cycles cause a starvation error
        gap_at = 2; gap_left = 20;
        do_xfer(64'h3000, 16'd16, 16'h0021, 50);
        chk("t3t_err",  {63'h0, transfer_error}, 64'h1);
        chk("t3t_done", {63'h0, transfer_done}, 64'h0);
        chk("t3t_busy_cycles", 64'(n_busy), 64'd10);
        gap_left = 0;
        cyc();
        cyc();
        cyc();
        chk("t3t_nwr", 64'(nwr), 64'd2);
        chk("t3t_err_held", {63'h0, transfer_error}, 64'h1);
        release_start();
        chk("t3t_err_clr", {63'h0, transfer_error}, 64'h0);

        // 4: rejected descriptors
        gap_at = -1; gap_left = 0;
        do_xfer(64'h1000, 16'd16, 16'h0020, 10);
        chk("t4_novalid_err", {63'h0, transfer_error}, 64'h1);
        chk("t4_novalid_nwr", 64'(nwr), 64'd0);
        release_start();
        do_xfer(64'h1002, 16'd16, 16'h0021, 10);
        chk("t4_align_err", {63'h0, transfer_error}, 64'h1);
        chk("t4_align_nwr", 64'(nwr + n_busy), 64'd0);
        release_start();
        do_xfer(64'h1000, 16'd16, 16'h0031, 10);
        chk("t4_link_err", {63'h0, transfer_error}, 64'h1);
        chk("t4_link_nwr", 64'(nwr), 64'd0);
        release_start();

        // 5a: stop after the second write
        address_descriptor = {64'h5000, 16'd16, 16'h0021};
        start = 1'b1; nwr = 0; n_busy = 0; head = 0;
        cyc();
        cyc();
        cyc();
        stop = 1'b1;
        start = 1'b0;
        #1;
        chk("t5_stop_mask_wr", {63'h0, ram_write}, 64'h0);
        chk("t5_stop_mask_rd", {63'h0, fifo_read}, 64'h0);
        cyc();
        stop = 1'b0;
        chk("t5_busy", {63'h0, busy}, 64'h0);
        chk("t5_done", {63'h0, transfer_done}, 64'h0);
        chk("t5_err",  {63'h0, transfer_error}, 64'h0);
        chk("t5_nwr",  64'(nwr), 64'd2);

        // 5b: RESET in the middle of XFER
        address_descriptor = {64'h6000, 16'd16, 16'h0021};
        start = 1'b1; nwr = 0; head = 0;
        cyc();
        cyc();
        #1;
        chk("t5r_pre_wr", {63'h0, ram_write}, 64'h1);
        RESET = 1'b1;
        #1;
        chk("t5r_busy", {63'h0, busy}, 64'h0);
        chk("t5r_wr",   {63'h0, ram_write}, 64'h0);
        chk("t5r_rd",   {63'h0, fifo_read}, 64'h0);
        chk("t5r_addr", ram_address, 64'h0);
        start = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        cyc();
        chk("t5r_idle_nwr", 64'(nwr), 64'd1);

        // 6: address wraps from the top of the space to zero
        do_xfer(64'hFFFF_FFFF_FFFF_FFFC, 16'd8, 16'h0021, 20);
        chk("t6_done",  {63'h0, transfer_done}, 64'h1);
        chk("t6_nwr",   64'(nwr), 64'd2);
        chk("t6_addr0", wa[0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_addr1", wa[1], 64'h0);
        release_start();

        // Properties accumulated over every logged cycle
        chk("strobes_equal", 64'(n_strobe_bad), 64'd0);
        chk("data_zero_idle", 64'(n_dirty), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
